// File: rtl/object_renderer_axi_slave.sv
// -----------------------------------------------------------------------------
// object_renderer_axi_slave
//
// AXI4-Lite responder holding the four 32-bit object-description registers of
// the object renderer. Register contents are exported continuously, and a
// one-cycle obj_commit pulse follows every write that lands on reg3 (the
// control register), so the renderer can latch a coherent object description.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN   clock, synchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*   write address, data and response channels
//   S_AXI_AR* / S_AXI_R*              read address and data channels
//   obj_reg0..obj_reg3           current register contents
//   obj_commit                   one-cycle pulse after a write to reg3
//
// Addressing: index = addr[3:2]; addr[1:0] and the PROT inputs are ignored.
// All responses are OKAY.
// -----------------------------------------------------------------------------
module object_renderer_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     obj_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     obj_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     obj_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     obj_reg3,
    output logic                              obj_commit
);

    localparam int ADDR_LSB = 2;
    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

    // Write-side holding state: an address or data beat accepted before its
    // partner arrives waits here until the commit.
    logic                          aw_held;
    logic                          w_held;
    logic [1:0]                    aw_idx_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]             wstrb_q;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          wr_commit;
    logic [1:0]                    wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]             wr_strb;
    logic [1:0]                    rd_idx;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Replace only the byte lanes whose strobe is set.
    function automatic logic [C_S_AXI_DATA_WIDTH-1:0] byte_merge(
        input logic [C_S_AXI_DATA_WIDTH-1:0] old_v,
        input logic [C_S_AXI_DATA_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]             strb
    );
        logic [C_S_AXI_DATA_WIDTH-1:0] r;
        r = old_v;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    // A beat handshaking this cycle is used directly, so a write whose AW and W
    // complete on the same edge (or whose partner is already held) commits on
    // that very edge instead of waiting an extra cycle in the holding flags.
    always_comb begin
        aw_hs     = S_AXI_AWREADY && S_AXI_AWVALID;
        w_hs      = S_AXI_WREADY && S_AXI_WVALID;
        wr_idx    = aw_held ? aw_idx_q : S_AXI_AWADDR[ADDR_LSB +: 2];
        wr_data   = w_held ? wdata_q : S_AXI_WDATA;
        wr_strb   = w_held ? wstrb_q : S_AXI_WSTRB;
        wr_commit = (aw_held || aw_hs) && (w_held || w_hs) && !S_AXI_BVALID;
        rd_idx    = S_AXI_ARADDR[ADDR_LSB +: 2];
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            obj_commit    <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            // Write channel: ready pulses for one cycle; nothing new is taken
            // while a beat of the same kind is held or a response is pending.
            S_AXI_AWREADY <= S_AXI_AWVALID && !S_AXI_AWREADY && !aw_held && !S_AXI_BVALID;
            S_AXI_WREADY  <= S_AXI_WVALID && !S_AXI_WREADY && !w_held && !S_AXI_BVALID;
            S_AXI_BRESP   <= 2'b00;

            if (wr_commit) begin
                regs[wr_idx] <= byte_merge(regs[wr_idx], wr_data, wr_strb);
                S_AXI_BVALID <= 1'b1;
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= S_AXI_AWADDR[ADDR_LSB +: 2];
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    wdata_q <= S_AXI_WDATA;
                    wstrb_q <= S_AXI_WSTRB;
                end
                if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            end

            // Pulses on reg3 writes even with an all-zero strobe.
            obj_commit <= wr_commit && (wr_idx == 2'd3);

            // Read channel: RDATA samples the registers before any write that
            // commits on the same edge, so a coincident read sees the old value.
            S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;
            S_AXI_RRESP   <= 2'b00;
            if (S_AXI_ARREADY && S_AXI_ARVALID) begin
                S_AXI_RDATA  <= regs[rd_idx];
                S_AXI_RVALID <= 1'b1;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    assign obj_reg0 = regs[0];
    assign obj_reg1 = regs[1];
    assign obj_reg2 = regs[2];
    assign obj_reg3 = regs[3];

endmodule

// File: tb/tb_object_renderer_axi_slave.sv
// -----------------------------------------------------------------------------
// tb_object_renderer_axi_slave
//
// Self-checking bench for object_renderer_axi_slave. Inputs are driven and
// outputs sampled on the falling edge; a reference register file in the bench
// tracks expected contents from the byte-strobe rules.
// -----------------------------------------------------------------------------
module tb_object_renderer_axi_slave;

    logic        tb_ACLK = 1'b0;
    logic        tb_ARESETN;
    logic [3:0]  AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] obj_reg0, obj_reg1, obj_reg2, obj_reg3;
    logic        obj_commit;

    int total_checks = 0;
    int passed_checks = 0;
    int b_cnt = 0;
    int r_cnt = 0;
    int commit_cnt = 0;
    logic [31:0] model [4];

    always #5 tb_ACLK = ~tb_ACLK;

    object_renderer_axi_slave dut (
        .S_AXI_ACLK    (tb_ACLK),
        .S_AXI_ARESETN (tb_ARESETN),
        .S_AXI_AWADDR  (AWADDR),
        .S_AXI_AWPROT  (AWPROT),
        .S_AXI_AWVALID (AWVALID),
        .S_AXI_AWREADY (AWREADY),
        .S_AXI_WDATA   (WDATA),
        .S_AXI_WSTRB   (WSTRB),
        .S_AXI_WVALID  (WVALID),
        .S_AXI_WREADY  (WREADY),
        .S_AXI_BRESP   (BRESP),
        .S_AXI_BVALID  (BVALID),
        .S_AXI_BREADY  (BREADY),
        .S_AXI_ARADDR  (ARADDR),
        .S_AXI_ARPROT  (ARPROT),
        .S_AXI_ARVALID (ARVALID),
        .S_AXI_ARREADY (ARREADY),
        .S_AXI_RDATA   (RDATA),
        .S_AXI_RRESP   (RRESP),
        .S_AXI_RVALID  (RVALID),
        .S_AXI_RREADY  (RREADY),
        .obj_reg0      (obj_reg0),
        .obj_reg1      (obj_reg1),
        .obj_reg2      (obj_reg2),
        .obj_reg3      (obj_reg3),
        .obj_commit    (obj_commit)
    );

    // Handshake and pulse counters, sampled with the values in force at the edge.
    always @(posedge tb_ACLK) begin
        if (BVALID && BREADY) b_cnt <= b_cnt + 1;
        if (RVALID && RREADY) r_cnt <= r_cnt + 1;
        if (obj_commit) commit_cnt <= commit_cnt + 1;
    end

    function automatic logic [31:0] merge_ref(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int lead, input int b_hold, output bit early_b);
        int  n, aw_start, w_start, bwait;
        bit  aw_hs, w_hs, b_hs, aw_done, w_done, got_b;
        logic [1:0] bresp_seen;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        aw_done = 0; w_done = 0; got_b = 0; early_b = 0; bwait = 0; n = 0;
        bresp_seen = 2'b11;
        AWADDR = addr; WDATA = data; WSTRB = strb; AWPROT = 3'($urandom);
        AWVALID = (aw_start == 0);
        WVALID  = (w_start == 0);
        BREADY  = (b_hold == 0);
        while (!got_b && n < 100) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            b_hs  = BVALID && BREADY;
            if (BVALID && !aw_done) early_b = 1;
            if (b_hs) bresp_seen = BRESP;
            @(negedge tb_ACLK);
            n++;
            if (aw_hs) begin AWVALID = 0; aw_done = 1; end
            if (w_hs)  begin WVALID = 0; w_done = 1; end
            if (b_hs)  begin got_b = 1; BREADY = 0; end
            if (!aw_done && aw_start > 0 && n == aw_start) AWVALID = 1;
            if (!w_done && w_start > 0 && n == w_start) WVALID = 1;
            if (!got_b && BVALID && !BREADY) begin
                bwait++;
                if (bwait >= b_hold) BREADY = 1;
            end
        end
        AWVALID = 0; WVALID = 0; BREADY = 0;
        total_checks++;
        if (!got_b) $display("FAIL write_timeout addr=%h: no B beat within 100 cycles", addr);
        else if (bresp_seen !== 2'b00) $display("FAIL bresp addr=%h: got %b want 00", addr, bresp_seen);
        else passed_checks++;
        model[addr[3:2]] = merge_ref(model[addr[3:2]], data, strb);
    endtask

    task automatic do_read(input logic [3:0] addr, input int r_hold, output logic [31:0] data);
        int  n, rwait;
        bit  ar_hs, r_hs, got, first, unstable;
        logic [31:0] held;
        logic [1:0]  rresp_seen;
        n = 0; rwait = 0; got = 0; first = 1; unstable = 0;
        held = '0; data = 'x; rresp_seen = 2'b11;
        ARADDR = addr; ARPROT = 3'($urandom); ARVALID = 1; RREADY = (r_hold == 0);
        while (!got && n < 100) begin
            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            if (RVALID) begin
                if (first) begin held = RDATA; first = 0; end
                else if (RDATA !== held) unstable = 1;
            end
            if (r_hs) begin data = RDATA; rresp_seen = RRESP; end
            @(negedge tb_ACLK);
            n++;
            if (ar_hs) ARVALID = 0;
            if (r_hs) begin got = 1; RREADY = 0; end
            else if (RVALID && !RREADY) begin
                rwait++;
                if (rwait >= r_hold) RREADY = 1;
            end
        end
        ARVALID = 0; RREADY = 0;
        total_checks++;
        if (!got) $display("FAIL read_timeout addr=%h: no R beat within 100 cycles", addr);
        else if (rresp_seen !== 2'b00 || unstable)
            $display("FAIL rresp_stable addr=%h: rresp=%b unstable=%0d want 00/0", addr, rresp_seen, unstable);
        else passed_checks++;
    endtask

    task automatic test_reset;
        tb_ARESETN = 0;
        AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 0;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        repeat (3) @(negedge tb_ACLK);
        total_checks++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, obj_commit, BRESP, RRESP} !== 10'b0)
            $display("FAIL reset_ctrl: got %b want 0",
                     {AWREADY, WREADY, BVALID, ARREADY, RVALID, obj_commit, BRESP, RRESP});
        else passed_checks++;
        total_checks++;
        if ({RDATA, obj_reg0, obj_reg1, obj_reg2, obj_reg3} !== 160'h0)
            $display("FAIL reset_data: rdata=%h regs=%h %h %h %h want 0",
                     RDATA, obj_reg0, obj_reg1, obj_reg2, obj_reg3);
        else passed_checks++;
        tb_ARESETN = 1;
        @(negedge tb_ACLK);
    endtask

    task automatic test_basic;
        logic [31:0] vals [4];
        logic [31:0] rd;
        bit eb;
        int c0;
        vals[0] = 32'h0101FFFF; vals[1] = 32'hABCD0001; vals[2] = 32'hDEAD0011; vals[3] = 32'hBEEF0011;
        c0 = commit_cnt;
        for (int i = 0; i < 4; i++) begin
            do_write(4'(i * 4), vals[i], 4'hF, 0, 0, eb);
            do_read(4'(i * 4), 0, rd);
            total_checks++;
            if (rd !== vals[i]) $display("FAIL basic_read%0d: got %h want %h", i, rd, vals[i]);
            else passed_checks++;
        end
        total_checks++;
        if (commit_cnt - c0 !== 1) $display("FAIL basic_commit_count: got %0d want 1", commit_cnt - c0);
        else passed_checks++;
        total_checks++;
        if ({obj_reg0, obj_reg1, obj_reg2, obj_reg3} !== {vals[0], vals[1], vals[2], vals[3]})
            $display("FAIL basic_obj_regs: got %h %h %h %h", obj_reg0, obj_reg1, obj_reg2, obj_reg3);
        else passed_checks++;
    endtask

    task automatic test_strobe;
        logic [31:0] rd;
        bit eb;
        do_write(4'h4, 32'hABCD0001, 4'hF, 0, 0, eb);
        do_write(4'h5, 32'h12345678, 4'b0101, 0, 0, eb);
        do_read(4'h6, 1, rd);
        total_checks++;
        if (rd !== 32'hAB340078) $display("FAIL strobe_merge: got %h want ab340078", rd);
        else passed_checks++;
    endtask

    task automatic test_w_first;
        logic [31:0] rd;
        bit eb;
        int b0;
        b0 = b_cnt;
        do_write(4'h8, 32'hC0FFEE42, 4'hF, 3, 0, eb);
        repeat (3) @(negedge tb_ACLK);
        total_checks++;
        if (eb) $display("FAIL w_first_early_b: got BVALID before AW accepted, want none");
        else passed_checks++;
        total_checks++;
        if (b_cnt - b0 !== 1) $display("FAIL w_first_b_beats: got %0d want 1", b_cnt - b0);
        else passed_checks++;
        do_read(4'h8, 0, rd);
        total_checks++;
        if (rd !== 32'hC0FFEE42) $display("FAIL w_first_data: got %h want c0ffee42", rd);
        else passed_checks++;
    endtask

    task automatic test_back_pressure;
        logic [31:0] rd;
        bit aw_hs, w_hs, eb, stall_bad;
        int n;
        AWADDR = 4'h0; WDATA = 32'h5A5A1234; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 0;
        n = 0;
        while (!BVALID && n < 20) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            @(negedge tb_ACLK);
            n++;
            if (aw_hs) AWVALID = 0;
            if (w_hs)  WVALID = 0;
        end
        total_checks++;
        if (BVALID !== 1'b1) $display("FAIL bp_first_bvalid: got %b want 1", BVALID);
        else passed_checks++;
        model[0] = 32'h5A5A1234;
        AWVALID = 0; WVALID = 0;
        AWADDR = 4'h4; WDATA = 32'h0BADF00D; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge tb_ACLK);
            if (BVALID !== 1'b1 || AWREADY !== 1'b0 || WREADY !== 1'b0) stall_bad = 1;
        end
        total_checks++;
        if (stall_bad) $display("FAIL bp_stall: b/aw/w ready = %b%b%b want 100", BVALID, AWREADY, WREADY);
        else passed_checks++;
        BREADY = 1;
        @(negedge tb_ACLK);
        do_write(4'h4, 32'h0BADF00D, 4'hF, 0, 0, eb);
        do_read(4'h0, 0, rd);
        total_checks++;
        if (rd !== 32'h5A5A1234) $display("FAIL bp_reg0: got %h want 5a5a1234", rd);
        else passed_checks++;
        do_read(4'h4, 2, rd);
        total_checks++;
        if (rd !== 32'h0BADF00D) $display("FAIL bp_reg1: got %h want 0badf00d", rd);
        else passed_checks++;
    endtask

    task automatic test_same_edge;
        logic [31:0] rd;
        bit eb;
        do_write(4'h0, 32'h0101FFFF, 4'hF, 0, 0, eb);
        AWADDR = 4'h0; WDATA = 32'h0; WSTRB = 4'hF; AWVALID = 1; WVALID = 1; BREADY = 1;
        ARADDR = 4'h0; ARVALID = 1; RREADY = 0;
        @(negedge tb_ACLK);
        total_checks++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111)
            $display("FAIL same_edge_ready: got %b want 111", {AWREADY, WREADY, ARREADY});
        else passed_checks++;
        @(negedge tb_ACLK);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        total_checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'h0101FFFF)
            $display("FAIL same_edge_rdata: rvalid=%b rdata=%h want 1/0101ffff", RVALID, RDATA);
        else passed_checks++;
        total_checks++;
        if (BVALID !== 1'b1 || obj_reg0 !== 32'h0)
            $display("FAIL same_edge_write: bvalid=%b reg0=%h want 1/00000000", BVALID, obj_reg0);
        else passed_checks++;
        RREADY = 1;
        @(negedge tb_ACLK);
        RREADY = 0; BREADY = 0;
        model[0] = 32'h0;
        do_read(4'h0, 0, rd);
        total_checks++;
        if (rd !== 32'h0) $display("FAIL same_edge_after: got %h want 00000000", rd);
        else passed_checks++;
    endtask

    task automatic test_random;
        logic [3:0]  addr;
        logic [31:0] data, rd;
        logic [3:0]  strb;
        bit eb;
        int c0;
        for (int i = 0; i < 40; i++) begin
            addr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                c0 = commit_cnt;
                do_write(addr, data, strb, $urandom_range(0, 6) - 3, $urandom_range(0, 3), eb);
                total_checks++;
                if ({obj_reg0, obj_reg1, obj_reg2, obj_reg3} !== {model[0], model[1], model[2], model[3]})
                    $display("FAIL rand_regs op%0d: got %h %h %h %h want %h %h %h %h", i,
                             obj_reg0, obj_reg1, obj_reg2, obj_reg3, model[0], model[1], model[2], model[3]);
                else passed_checks++;
                total_checks++;
                if (commit_cnt - c0 !== ((addr[3:2] == 2'd3) ? 1 : 0))
                    $display("FAIL rand_commit op%0d addr=%h: got %0d pulses", i, addr, commit_cnt - c0);
                else passed_checks++;
            end else begin
                do_read(addr, $urandom_range(0, 3), rd);
                total_checks++;
                if (rd !== model[addr[3:2]])
                    $display("FAIL rand_read op%0d addr=%h: got %h want %h", i, addr, rd, model[addr[3:2]]);
                else passed_checks++;
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        bit ar_hs;
        int n, b0, r0;
        ARADDR = 4'h8; ARVALID = 1; RREADY = 0;
        n = 0;
        while (!RVALID && n < 20) begin
            ar_hs = ARVALID && ARREADY;
            @(negedge tb_ACLK);
            n++;
            if (ar_hs) ARVALID = 0;
        end
        ARVALID = 0;
        total_checks++;
        if (RVALID !== 1'b1) $display("FAIL rst_mid_rvalid_before: got %b want 1", RVALID);
        else passed_checks++;
        b0 = b_cnt; r0 = r_cnt;
        tb_ARESETN = 0;
        @(negedge tb_ACLK);
        total_checks++;
        if (RVALID !== 1'b0 || obj_commit !== 1'b0)
            $display("FAIL rst_mid_ctrl: rvalid=%b commit=%b want 0/0", RVALID, obj_commit);
        else passed_checks++;
        tb_ARESETN = 1;
        RREADY = 1;
        repeat (3) @(negedge tb_ACLK);
        RREADY = 0;
        total_checks++;
        if (b_cnt !== b0 || r_cnt !== r0)
            $display("FAIL rst_mid_no_beat: got b=%0d r=%0d extra beats want 0", b_cnt - b0, r_cnt - r0);
        else passed_checks++;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            do_read(4'(i * 4), 0, rd);
            total_checks++;
            if (rd !== 32'h0) $display("FAIL rst_mid_reg%0d: got %h want 00000000", i, rd);
            else passed_checks++;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_strobe;
        test_w_first;
        test_back_pressure;
        test_same_edge;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
